// File: rtl/rvv_backend_rob_wr_arb_if.sv
// Result payload type and the PU/ROB write-back bus shared by the arbiter and its environment.
// The arbiter uses the slave modport; the PUs and ROB together drive the master side.
package rvv_backend_rob_wr_arb_pkg;
   typedef struct packed {
      logic [3:0]  rob_entry;
      logic        w_valid;
      logic [63:0] w_data;
      logic [7:0]  vsaturate;
   } PU2ROB_t;
endpackage

interface rvv_backend_rob_wr_arb_if #(
   parameter int NUM_REQ  = 9,
   parameter int NUM_PORT = 4
);
   import rvv_backend_rob_wr_arb_pkg::*;

   // valid/ready: a transfer happens on a clock edge where valid and ready are both 1;
   // a source holds valid and data stable until that edge.
   logic [NUM_REQ-1:0]  req_valid;
   PU2ROB_t             req_data [NUM_REQ];
   logic [NUM_REQ-1:0]  req_ready;
   logic [NUM_PORT-1:0] wr_valid;
   PU2ROB_t             wr_data [NUM_PORT];
   logic [NUM_PORT-1:0] wr_ready;

   modport master (
      output req_valid, req_data, wr_ready,
      input  req_ready, wr_valid, wr_data
   );

   modport slave (
      input  req_valid, req_data, wr_ready,
      output req_ready, wr_valid, wr_data
   );
endinterface

// File: rtl/rvv_backend_rob_wr_arb.sv
// Round-robin write-back arbiter: NUM_REQ PU result streams onto NUM_PORT registered ROB ports.
// Optional performance counters are enabled with `define ROB_WR_ARB_PERF_EN.
module rvv_backend_rob_wr_arb
   import rvv_backend_rob_wr_arb_pkg::*;
#(
   parameter int NUM_REQ  = 9,
   parameter int NUM_PORT = 4,
   parameter int PTR_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   rvv_backend_rob_wr_arb_if.slave bus,
`ifdef ROB_WR_ARB_PERF_EN
   output logic [31:0]             perf_grant_cnt,
   output logic [31:0]             perf_stall_cnt,
`endif
   output logic [PTR_W-1:0]        rr_ptr
);

   logic [NUM_PORT-1:0] load;
   logic [NUM_REQ-1:0]  grant;
   logic [PTR_W-1:0]    slot_req [NUM_PORT];
   logic [NUM_PORT-1:0] port_load;
   logic [PTR_W-1:0]    port_src [NUM_PORT];
   logic [PTR_W-1:0]    rr_ptr_nxt;
   logic                any_grant;

   assign load          = ~bus.wr_valid | bus.wr_ready;
   assign bus.req_ready = grant;

   // Scan requesters from rr_ptr; the n-th valid one fills the n-th loadable port.
   always_comb begin
      int n_load;
      int n_gnt;
      int rank;
      logic [PTR_W:0]   idx_w;
      logic [PTR_W-1:0] idx;
      grant      = '0;
      port_load  = '0;
      any_grant  = 1'b0;
      rr_ptr_nxt = rr_ptr;
      n_load     = 0;
      n_gnt      = 0;
      rank       = 0;
      idx_w      = '0;
      idx        = '0;
      for (int k = 0; k < NUM_PORT; k++) begin
         slot_req[k] = '0;
         port_src[k] = '0;
      end
      for (int k = 0; k < NUM_PORT; k++) begin
         if (load[k]) n_load = n_load + 1;
      end
      // Nothing is honoured while reset is held.
      if (!rst_n) n_load = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_w = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (idx_w >= (PTR_W+1)'(NUM_REQ)) idx_w = idx_w - (PTR_W+1)'(NUM_REQ);
         idx = idx_w[PTR_W-1:0];
         if (bus.req_valid[idx] && (n_gnt < n_load)) begin
            grant[idx] = 1'b1;
            for (int s = 0; s < NUM_PORT; s++) begin
               if (s == n_gnt) slot_req[s] = idx;
            end
            n_gnt      = n_gnt + 1;
            any_grant  = 1'b1;
            rr_ptr_nxt = (idx == PTR_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
         end
      end
      for (int k = 0; k < NUM_PORT; k++) begin
         if (load[k]) begin
            if (rank < n_gnt) begin
               port_load[k] = 1'b1;
               for (int s = 0; s < NUM_PORT; s++) begin
                  if (s == rank) port_src[k] = slot_req[s];
               end
            end
            rank = rank + 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         for (int k = 0; k < NUM_PORT; k++) begin
            bus.wr_valid[k] <= 1'b0;
            bus.wr_data[k]  <= '0;
         end
      end else begin
         if (any_grant) rr_ptr <= rr_ptr_nxt;
         // Stalled ports are never in port_load and do not see wr_ready, so they hold.
         for (int k = 0; k < NUM_PORT; k++) begin
            if (port_load[k]) begin
               bus.wr_valid[k] <= 1'b1;
               bus.wr_data[k]  <= bus.req_data[port_src[k]];
            end else if (bus.wr_ready[k]) begin
               bus.wr_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef ROB_WR_ARB_PERF_EN
   logic [31:0] grant_pop;
   logic [32:0] grant_sum;
   logic        stall_now;

   always_comb begin
      grant_pop = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         grant_pop = grant_pop + 32'(grant[r]);
      end
      grant_sum = {1'b0, perf_grant_cnt} + {1'b0, grant_pop};
      stall_now = |(bus.req_valid & ~grant);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         perf_grant_cnt <= grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
         if (stall_now && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
